mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store bridge between the multicycle CPU datapath and the word-organised data RAM.
- Performs three functions:
  - accepts byte, halfword and word requests;
  - performs read-modify-write for sub-word stores;
  - extracts and sign- or zero-extends sub-word loads.
- Flags misaligned, reserved-size and out-of-range accesses.
- Drives the RAM's combinational-read / synchronous-write port directly; the RAM sits immediately downstream.

Parameters:
RAM_WORDS, 64, number of 32-bit words in the downstream RAM; word index >= RAM_WORDS is an error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  unit can accept request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extend when 1, sign-extend when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  1  valid with resp_valid; access rejected
ram_addr  output  32  word-aligned byte address to RAM ({addr_q[31:2],2'b00})
ram_rdata  input  32  RAM combinational read data
ram_we  output  1  RAM write enable, sampled on clk rising edge
ram_wdata  output  32  RAM write data

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all latched fields=0.
  - Outputs: ram_addr=0, ram_we=0, ram_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 after release.
- Handshake: request accepted on a rising edge where req_valid&&req_ready. Latch addr_q, size_q, we_q, uns_q, wdata_q. Only one request outstanding. req_valid is ignored outside IDLE.
- Error check at acceptance (err if any holds):
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= RAM_WORDS.
- Lanes are little-endian:
  - byte k = bits[8k+7:8k], k=addr[1:0];
  - half h = bits[16h+15:16h], h=addr[1].
- States and transitions:
  - IDLE: accept request.
    - err -> RESP(err).
    - load -> LOAD.
    - word store -> WRITE (merge_q=wdata).
    - byte/half store -> RMW_RD.
  - LOAD: sample ram_rdata; extract lane; extend per uns_q into rdata_q -> RESP.
  - RMW_RD: sample ram_rdata; replace target lane with wdata_q low bits; store into merge_q -> WRITE.
  - WRITE: ram_we=1 for exactly this cycle; ram_wdata=merge_q -> RESP.
  - RESP: resp_valid=1 for one cycle; resp_err=err_q; resp_rdata=rdata_q for an error-free load, else 0 -> IDLE.
- Latency (accept edge = T):
  - load: resp_valid during cycle T+2.
  - word store: ram_we during T+1, resp during T+2.
  - sub-word store: ram_we during T+2, resp during T+3.
  - error: resp during T+1, no RAM write.
- ram_we is a decode of state==WRITE only. It is never asserted for errors or loads.
- ram_addr holds addr_q in every state; low 2 bits are always 0.
- Back-to-back: a new request may be accepted in the cycle after RESP (IDLE). No response backpressure; the CPU must take the pulse.
- Reset mid-operation (any state) returns to IDLE immediately. ram_we drops asynchronously; no partial write and no response is issued.
- Extension: byte signed uses bit7; half signed uses bit15. Word loads ignore req_unsigned.

Test Plan:
- Word store/load:
  - store word 0xDEADBEEF @0x10 -> ram_we high during T+1 only, ram_addr=0x10, ram_wdata=0xDEADBEEF, resp_valid at T+2 with err=0.
  - then load word @0x10 -> resp_rdata=0xDEADBEEF at T+2.
- Byte RMW:
  - RAM[4]=0x11223344; store byte 0xAA @0x12 -> ram_wdata=0x11AA3344 at T+2, resp at T+3.
  - neighbouring lanes unchanged on reload.
- Extension: RAM[4]=0x80FF7F01.
  - load byte signed @0x13 -> 0xFFFFFF80.
  - load byte unsigned @0x13 -> 0x00000080.
  - load half signed @0x10 -> 0x00007F01.
  - load half signed @0x12 -> 0xFFFF80FF.
- Errors: each of the following -> resp_valid at T+1, resp_err=1, resp_rdata=0, ram_we never asserted, RAM unchanged:
  - half @0x11;
  - word @0x0E;
  - size=11;
  - word @0x100 (index 64 with RAM_WORDS=64).
- Handshake: req_valid held high across a sub-word store -> req_ready low from T+1 to T+3, second request accepted only at the edge after RESP, with no lost or duplicated writes.
- Reset: assert rst_n low during RMW_RD of a byte store -> ram_we stays 0, no resp_valid, RAM word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// CPU request/response and RAM port bundle for the load/store bridge.
// The slave side is the bridge; the master side is the CPU plus the RAM.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic [31:0] ram_wdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store bridge: byte/half/word requests onto a word RAM with read-modify-write
// for sub-word stores and sign/zero extension for sub-word loads.
module mem_access_unit #(
    parameter int unsigned RAM_WORDS = 64
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic [15:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        acc_err;

    // Pull the addressed little-endian lane out of a RAM word and widen it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offs,
                                                input logic        uns);
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic signed [31:0] ext;
        lane_b = word[8*offs +: 8];
        lane_h = word[16*offs[1] +: 16];
        case (size)
            2'b00:   ext = uns ? 32'($unsigned(lane_b)) : 32'(lane_b);
            2'b01:   ext = uns ? 32'($unsigned(lane_h)) : 32'(lane_h);
            default: ext = $signed(word);
        endcase
        return ext;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [15:0] wdata,
                                                input logic        half,
                                                input logic [1:0]  offs);
        logic [31:0] m;
        m = old;
        if (half) m[16*offs[1] +: 16] = wdata;
        else      m[8*offs +: 8]      = wdata[7:0];
        return m;
    endfunction

    assign accept  = bus.req_valid && (state == IDLE);
    assign acc_err = (bus.req_size == 2'b11)
                  || ((bus.req_size == 2'b01) && bus.req_addr[0])
                  || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                  || ({2'b00, bus.req_addr[31:2]} >= RAM_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_err)                    state_nxt = RESP;
                    else if (!bus.req_we)           state_nxt = LOAD;
                    else if (bus.req_size == 2'b10) state_nxt = WRITE;
                    else                            state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = RESP;
            RMW_RD:  state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.req_addr;
                        size_q  <= bus.req_size;
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        err_q   <= acc_err;
                        wdata_q <= bus.req_wdata[15:0];
                        merge_q <= bus.req_wdata;
                        rdata_q <= '0;
                    end
                end
                LOAD:    rdata_q <= load_extend(bus.ram_rdata, size_q, addr_q[1:0], uns_q);
                RMW_RD:  merge_q <= store_merge(bus.ram_rdata, wdata_q, size_q[0], addr_q[1:0]);
                default: ;
            endcase
        end
    end

    // Outputs are pure state decodes so an async reset drops ram_we immediately.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.ram_we     = (state == WRITE);
        bus.resp_valid = (state == RESP);
        bus.resp_err   = (state == RESP) && err_q;
        bus.resp_rdata = '0;
        if ((state == RESP) && !err_q && !we_q) bus.resp_rdata = rdata_q;
        bus.ram_addr   = {addr_q[31:2], 2'b00};
        bus.ram_wdata  = merge_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: word-array RAM model, directed cases, random traffic.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   fill = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit #(.RAM_WORDS(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    resp_t mr;
    wr_t   mw;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A3C9617;
    endfunction

    assign bus.ram_rdata = mem[bus.ram_addr[7:2]];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
        end
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input int size, input int k, input bit uns);
        logic [31:0] v;
        if (size == 0) begin
            v = (w >> (8 * k)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (size == 1) begin
            v = (w >> (16 * (k / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd, input int size, input int k);
        logic [31:0] mask;
        int sh;
        sh   = (size == 0) ? 8 * k : 16 * (k / 2);
        mask = ((size == 0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Monitor: every response and every RAM write must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && !fill) begin
            if (bus.resp_valid) begin
                if (rq.size() == 0) begin
                    check32("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    mr = rq.pop_front();
                    check32("resp_rdata", bus.resp_rdata, mr.rdata);
                    check32("resp_err", 32'(bus.resp_err), 32'(mr.err));
                    check32("resp_cycle", cyc, mr.due);
                end
            end
            if (bus.ram_we) begin
                if (wq.size() == 0) begin
                    check32("ram_we_unexpected", 32'd1, 32'd0);
                end else begin
                    mw = wq.pop_front();
                    check32("ram_addr", bus.ram_addr, mw.addr);
                    check32("ram_wdata", bus.ram_wdata, mw.data);
                    check32("ram_we_cycle", cyc, mw.due);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
    task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit track);
        int waitc;
        int c;
        int idx;
        int k;
        bit err;
        logic [31:0] nw;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        waitc = 0;
        while (!bus.req_ready) begin
            waitc++;
            if (waitc > 20) begin
                check32("accept_timeout", 32'd1, 32'd0);
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        c = cyc;
        if (track) begin
            idx = int'(addr / 4);
            k   = int'(addr % 4);
            err = (size == 2'b11) || (size == 2'b01 && (addr % 2) != 0)
               || (size == 2'b10 && k != 0) || (idx >= 64);
            if (err) begin
                rq.push_back('{32'h0, 1'b1, c + 1});
            end else if (!we) begin
                rq.push_back('{model_load(ref_mem[idx], int'(size), k, uns), 1'b0, c + 2});
            end else if (size == 2'b10) begin
                ref_mem[idx] = wd;
                wq.push_back('{addr, wd, c + 1});
                rq.push_back('{32'h0, 1'b0, c + 2});
            end else begin
                nw = model_merge(ref_mem[idx], wd, int'(size), k);
                ref_mem[idx] = nw;
                wq.push_back('{addr & ~32'h3, nw, c + 2});
                rq.push_back('{32'h0, 1'b0, c + 3});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);

        repeat (3) @(negedge clk);
        check32("rst_ram_addr", bus.ram_addr, 32'h0);
        check32("rst_ram_we", 32'(bus.ram_we), 32'h0);
        check32("rst_ram_wdata", bus.ram_wdata, 32'h0);
        check32("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check32("rst_resp_err", 32'(bus.resp_err), 32'h0);
        check32("rst_resp_rdata", bus.resp_rdata, 32'h0);
        fill  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check32("rst_req_ready", 32'(bus.req_ready), 32'h1);

        // Word store/load, byte RMW and sign/zero extension.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1); idle(2);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);        idle(2);
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b1); idle(2);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AA, 1'b1); idle(3);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);        idle(2);
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);        idle(2);

        // Rejected accesses.
        issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h0E, 32'hCAFEF00D, 1'b1);
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h5555AAAA, 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h01234567, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);        idle(2);

        // req_valid held high across a sub-word store.
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000007E, 1'b1);
        bus.req_we = 1'b1; bus.req_size = 2'b01; bus.req_addr = 32'h22; bus.req_wdata = 32'h0000BEEF;
        check32("busy_t1", 32'(bus.req_ready), 32'h0);
        @(negedge clk); check32("busy_t2", 32'(bus.req_ready), 32'h0);
        @(negedge clk); check32("busy_t3", 32'(bus.req_ready), 32'h0);
        @(negedge clk); check32("ready_after_resp", 32'(bus.req_ready), 32'h1);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);        idle(2);

        // Reset while the byte store is in its read phase.
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000C3, 1'b0);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check32("midrst_ram_we", 32'(bus.ram_we), 32'h0);
        check32("midrst_resp_valid", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        check32("midrst_ram_we_hold", 32'(bus.ram_we), 32'h0);
        check32("midrst_resp_hold", 32'(bus.resp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check32("midrst_req_ready", 32'(bus.req_ready), 32'h1);
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);        idle(2);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [1:0]  sz;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(0, 255));
            if (sz == 2'b10 && $urandom_range(0, 3) != 0) a = a & ~32'h3;
            if (sz == 2'b01 && $urandom_range(0, 3) != 0) a = a & ~32'h1;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        for (int i = 0; i < 50 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
        check32("pending_resp", 32'(rq.size()), 32'h0);
        check32("pending_writes", 32'(wq.size()), 32'h0);
        for (int i = 0; i < 64; i++) check32("final_ram", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
